// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word-array memory target with valid/ready request and pulsed response
module data_mem_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state, state_n;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic [31:0]           addr_q, wdata_q;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
  logic                  take, enter, acc_wr, acc_err;
  logic [31:0]           acc_addr, acc_wdata, off;
  logic [DEPTH_LOG2-1:0] idx;
  assign take      = state == IDLE && req_valid;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign rsp_valid = state == RESP;
  // next-state selection; a latency of one skips WAIT entirely
  always_comb begin
    state_n = state;
    if (take) state_n = LATENCY > 1 ? WAIT : RESP;
    else if (state == WAIT && cnt == 4'd1) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  // the access happens on the edge entering RESP; from IDLE that is the live request, otherwise the latched one
  always_comb begin
    enter     = state_n == RESP && state != RESP;
    acc_wr    = state == IDLE ? req_write : wr_q;
    acc_addr  = state == IDLE ? req_addr : addr_q;
    acc_wdata = state == IDLE ? req_wdata : wdata_q;
    off       = acc_addr - BASE_ADDR;
    acc_err   = acc_addr < BASE_ADDR || |off[1:0] || |(off >> (DEPTH_LOG2 + 2));
    idx       = off[DEPTH_LOG2+1:2];
  end
  // state, wait counter, request latches and registered response fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state     <= state_n;
      rsp_rdata <= enter && !acc_wr && !acc_err ? mem[idx] : '0;
      rsp_error <= enter && acc_err;
      if (take) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  // array write; held off while reset is asserted so an aborted store never lands
  always_ff @(posedge clk) begin
    if (enter && acc_wr && !acc_err && !rst) mem[idx] <= acc_wdata;
  end
endmodule
